// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the ALU command sequencer and its command FIFO.
//   seq_state_t     : sequencer FSM states (IDLE, ISSUE, WAIT, RESP)
//   OP_*            : 2-bit ALU opcodes (add, sub, mul, div)
//   alu_cmd_t       : one queued command {opcode, a, b}, 18 bits packed
//   wait_cnt_width  : width of the WAIT-state counter (never narrower than 8)
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef struct packed {
    logic [1:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

  // Counter must hold TIMEOUT_CYCLES-1; keep at least 8 bits so small limits
  // still get a byte-wide counter.
  function automatic int wait_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous command FIFO, DEPTH entries of alu_cmd_t (18 bits).
// Pointers carry one extra MSB so full and empty are told apart without a
// separate counter. The read data is a register that always holds the
// current head entry (first-word fall-through with a registered output), so
// the consumer can use rd_data in the same cycle it asserts pop.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset (pointers and read register)
//   push     in   write request; ignored while full
//   wr_data  in   entry to write
//   pop      in   read request; ignored while empty
//   rd_data  out  current head entry (valid while !empty)
//   full     out  DEPTH entries held
//   empty    out  no entries held
// -----------------------------------------------------------------------------
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  alu_cmd_t wr_data,
  input  logic     pop,
  output alu_cmd_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t       mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic [AW:0]    rd_ptr_next;
  alu_cmd_t       rd_data_reg;
  logic           push_ok;
  logic           pop_ok;

  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  // A push is judged on the flags before the edge only: a same-cycle pop does
  // not make room for a push while full.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign rd_ptr_next = pop_ok ? (rd_ptr_reg + 1'b1) : rd_ptr_reg;

  // Storage array, no reset, so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg <= rd_ptr_next;
      // The head after this edge is the entry at rd_ptr_next. If that slot is
      // being written right now (FIFO was empty or is draining to this entry),
      // forward the incoming word instead of the stale array contents.
      if (push_ok && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
        rd_data_reg <= wr_data;
      end else begin
        rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Initiator side of the ALU start/done handshake. Commands are queued in a
// DEPTH-entry FIFO; one operation is outstanding at a time. For each command
// the sequencer registers opcode/operands to the ALU, pulses alu_start for one
// cycle, waits for alu_done, captures alu_result and offers it on a
// valid/ready response channel. Results come back in command order.
//
// Optional feature (macro ALU_SEQ_TIMEOUT_EN): a WAIT-state counter aborts an
// operation after TIMEOUT_CYCLES cycles without done, returning res_data=0
// with res_timeout=1. Without the macro WAIT lasts until done and
// res_timeout is tied to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   cmd_valid    in   command offered
//   cmd_ready    out  FIFO not full
//   cmd_opcode   in   2-bit opcode (add/sub/mul/div)
//   cmd_a        in   operand A / dividend
//   cmd_b        in   operand B / multiplier / divisor
//   alu_start    out  one-cycle start pulse
//   alu_opcode   out  registered opcode, stable from ISSUE to the next pop
//   alu_a        out  registered operand A
//   alu_b        out  registered operand B
//   alu_done     in   ALU completion (only honoured in WAIT)
//   alu_result   in   ALU result bus
//   res_valid    out  result available
//   res_ready    in   consumer accepts result
//   res_data     out  captured result
//   res_opcode   out  opcode of the completed command
//   res_timeout  out  result produced by timeout abort
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       alu_start,
  output logic [1:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [1:0] res_opcode,
  output logic       res_timeout
);

  // Elaboration-time parameter sanity: FIFO depth must be a power of two
  // (pointer wrap relies on it) and at least 2; the timeout must be positive.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
      $error("alu_cmd_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  alu_cmd_t   push_cmd;
  alu_cmd_t   head_cmd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;

  seq_state_t state_reg;

  assign push_cmd = {cmd_opcode, cmd_a, cmd_b};
  assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid),
    .wr_data (push_cmd),
    .pop     (fifo_pop),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic       alu_start_reg;
  logic [1:0] alu_opcode_reg;
  logic [7:0] alu_a_reg;
  logic [7:0] alu_b_reg;
  logic       res_valid_reg;
  logic [7:0] res_data_reg;
  logic [1:0] res_opcode_reg;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = wait_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             res_timeout_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      // Abandons any operation in flight; no result is produced for it.
      state_reg      <= ST_IDLE;
      alu_start_reg  <= 1'b0;
      alu_opcode_reg <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      res_valid_reg  <= 1'b0;
      res_data_reg   <= '0;
      res_opcode_reg <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      wait_cnt_reg    <= '0;
      res_timeout_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // fifo_pop is asserted in this same condition; head_cmd is the
          // entry being removed.
          if (!fifo_empty) begin
            alu_opcode_reg <= head_cmd.opcode;
            alu_a_reg      <= head_cmd.a;
            alu_b_reg      <= head_cmd.b;
            alu_start_reg  <= 1'b1;
            state_reg      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // Start is high for exactly this cycle; a done seen here belongs to
          // nothing and is dropped.
          alu_start_reg <= 1'b0;
          state_reg     <= ST_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
          wait_cnt_reg  <= '0;
`endif
        end

        ST_WAIT: begin
          // done has priority over a timeout landing in the same cycle.
          if (alu_done) begin
            res_valid_reg  <= 1'b1;
            res_data_reg   <= alu_result;
            res_opcode_reg <= alu_opcode_reg;
            state_reg      <= ST_RESP;
`ifdef ALU_SEQ_TIMEOUT_EN
            res_timeout_reg <= 1'b0;
          end else if (wait_cnt_reg == WAIT_LIMIT) begin
            res_valid_reg   <= 1'b1;
            res_data_reg    <= 8'h00;
            res_opcode_reg  <= alu_opcode_reg;
            res_timeout_reg <= 1'b1;
            state_reg       <= ST_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
`endif
          end
        end

        ST_RESP: begin
          // res_* hold until the consumer takes the result.
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_start  = alu_start_reg;
  assign alu_opcode = alu_opcode_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign res_valid  = res_valid_reg;
  assign res_data   = res_data_reg;
  assign res_opcode = res_opcode_reg;

`ifdef ALU_SEQ_TIMEOUT_EN
  assign res_timeout = res_timeout_reg;
`else
  assign res_timeout = 1'b0;
`endif

endmodule
